// File: rtl/ifu_axi_master_pkg.sv
// ifu_axi_master_pkg: shared fetch-unit types, AXI response code and bus-width defaults.
// Default-width macros are only provided when the core defines are absent.
`default_nettype none

`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 31:0
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 31:0
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 1:0
`endif
`ifndef AXI_STRB_BUS
`define AXI_STRB_BUS 3:0
`endif
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package ifu_axi_master_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    HOLD   = 2'd3
  } ifu_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

`default_nettype wire

// File: rtl/ifu_inst_buf.sv
// ifu_inst_buf: one-entry holding register for a fetched instruction, its PC and error bit.
// Pop or flush returns the word to NOP; load captures a new response.
`default_nettype none

module ifu_inst_buf
  import ifu_axi_master_pkg::*;
#(
  parameter logic [`AXI_ADDR_BUS] RESET_PC = `CPU_RESET_ADDR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [`AXI_DATA_BUS] load_inst,
  input  logic [`AXI_ADDR_BUS] load_pc,
  input  logic                 load_err,
  output logic [`AXI_DATA_BUS] inst,
  output logic [`AXI_ADDR_BUS] inst_pc,
  output logic                 inst_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst     <= `INST_NOP;
      inst_pc  <= RESET_PC;
      inst_err <= 1'b0;
    end else if (flush || pop) begin
      // inst_pc keeps the last address so debug views still show where the word came from
      inst     <= `INST_NOP;
      inst_err <= 1'b0;
    end else if (load) begin
      inst     <= load_inst;
      inst_pc  <= load_pc;
      inst_err <= load_err;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_axi_master.sv
// ifu_axi_master: read-only AXI-lite instruction fetch master, one outstanding AR at a time.
// Optional IFU_TIMEOUT_EN adds a sticky response-timeout flag.
`default_nettype none

module ifu_axi_master
  import ifu_axi_master_pkg::*;
#(
  parameter logic [`AXI_ADDR_BUS] RESET_PC       = `CPU_RESET_ADDR,
  parameter int                   TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [`AXI_ADDR_BUS] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [`AXI_DATA_BUS] rdata,
  input  logic [`AXI_RESP_BUS] rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [`AXI_ADDR_BUS] awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [`AXI_DATA_BUS] wdata,
  output logic [`AXI_STRB_BUS] wstrb,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [`AXI_RESP_BUS] bresp,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic                 redirect_valid,
  input  logic [`AXI_ADDR_BUS] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [`AXI_DATA_BUS] inst,
  output logic [`AXI_ADDR_BUS] inst_pc,
  output logic                 inst_err,
  output logic                 fetch_timeout
);

  ifu_state_e           state;
  logic [`AXI_ADDR_BUS] pc;
  logic [`AXI_ADDR_BUS] pend_pc;
  logic                 drop;

  logic buf_load;
  logic buf_pop;
  logic buf_flush;

  assign awaddr  = '0;
  assign awvalid = 1'b0;
  assign wdata   = '0;
  assign wstrb   = '0;
  assign wvalid  = 1'b0;
  assign bready  = 1'b0;

  logic unused_wr_inputs;
  assign unused_wr_inputs = &{1'b0, awready, wready, bresp, bvalid};

  // AR address is the PC itself; pc never changes while REQ is pending
  assign araddr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pend_pc    <= RESET_PC;
      drop       <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (redirect_valid) pc <= redirect_pc;
          state   <= REQ;
          arvalid <= 1'b1;
        end
        REQ: begin
          if (redirect_valid) begin
            pend_pc <= redirect_pc;
            drop    <= 1'b1;
          end
          if (arready) begin
            state   <= WAIT_R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        WAIT_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            drop   <= 1'b0;
            if (drop || redirect_valid) begin
              // a redirect arriving with the data beats any older pending target
              pc      <= redirect_valid ? redirect_pc : pend_pc;
              state   <= REQ;
              arvalid <= 1'b1;
            end else begin
              state      <= HOLD;
              inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            pend_pc <= redirect_pc;
            drop    <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            pc         <= redirect_valid ? redirect_pc : pc + 32'd4;
            state      <= REQ;
            arvalid    <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign buf_load  = (state == WAIT_R) && rvalid && !drop && !redirect_valid;
  assign buf_pop   = (state == HOLD) && inst_ready && !redirect_valid;
  assign buf_flush = (state == HOLD) && redirect_valid;

  ifu_inst_buf #(
    .RESET_PC (RESET_PC)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .load_inst (rdata),
    .load_pc   (pc),
    .load_err  (rresp != AXI_RESP_OKAY),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_err  (inst_err)
  );

`ifdef IFU_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_flag;

  // flag rises on the same edge the counter reaches TIMEOUT_CYCLES; the FSM keeps waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (state == REQ && arready) begin
      wait_cnt <= '0;
    end else if (state == WAIT_R && !rvalid && wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == CNT_LAST) timeout_flag <= 1'b1;
    end
  end

  assign fetch_timeout = timeout_flag;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign fetch_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
